// File: rtl/axi_uart_tx_slave_pkg.sv
// axi_uart_tx_slave_pkg: register map, STAT bits, AXI response codes and TX state encoding
package axi_uart_tx_slave_pkg;
  localparam logic [3:0] ADDR_RX = 4'h0;
  localparam logic [3:0] ADDR_TX = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;
  localparam logic [3:0] ADDR_CTRL = 4'hC;
  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL = 3;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer; takes one byte while idle and shifts it out LSB first
module uart_tx
  import axi_uart_tx_slave_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  tx_state_t state, next;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic bit_done;
  assign bit_done = cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else begin
      state <= next;
      cnt <= (state == IDLE || bit_done) ? '0 : cnt + 1'b1;
      idx <= (state == DATA && bit_done) ? idx + 1'b1 : idx;
      sh <= (state == IDLE && valid) ? data : (state == DATA && bit_done) ? sh >> 1 : sh;
    end
  always_comb begin
    next = state;
    case (state)
      IDLE: next = valid ? START : IDLE;
      START: next = bit_done ? DATA : START;
      DATA: next = (bit_done && idx == 3'd7) ? STOP : DATA;
      STOP: next = bit_done ? IDLE : STOP;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    ready = state == IDLE;
    tx = state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
  end
endmodule

// File: rtl/axi_uart_tx_slave.sv
// axi_uart_tx_slave: AXI4-Lite UART transmitter with a TX FIFO feeding the uart_tx serializer
module axi_uart_tx_slave
  import axi_uart_tx_slave_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [31:0] stat;
  logic full, empty, wr_acc, rd_acc, push, pop, clear, ready;
  logic unused;
  assign unused = ^{s_axi_wstrb, s_axi_wdata[31:8]};
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  // handshakes are gated by reset so the ready outputs drop the moment reset asserts
  assign wr_acc = s_axi_aresetn && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
  assign rd_acc = s_axi_aresetn && s_axi_arvalid && !s_axi_rvalid;
  assign push = wr_acc && s_axi_awaddr == ADDR_TX && !full;
  assign clear = wr_acc && s_axi_awaddr == ADDR_CTRL && s_axi_wdata[0];
  assign pop = ready && !empty;
  assign s_axi_awready = wr_acc;
  assign s_axi_wready = wr_acc;
  assign s_axi_arready = rd_acc;
  assign s_axi_rresp = RESP_OKAY;
  always_comb begin
    stat = '0;
    stat[STAT_TX_EMPTY] = empty;
    stat[STAT_TX_FULL] = full;
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge s_axi_aclk)
    if (push) mem[wp] <= s_axi_wdata[7:0];
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata <= '0;
    end else begin
      if (wr_acc) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp <= (s_axi_awaddr == ADDR_TX && full) ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      if (rd_acc) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata <= s_axi_araddr == ADDR_STAT ? stat : '0;
      end else if (s_axi_rready) s_axi_rvalid <= 1'b0;
    end
  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(s_axi_aclk),
    .rst_n(s_axi_aresetn),
    .data(mem[rp]),
    .valid(!empty),
    .ready(ready),
    .tx(tx)
  );
endmodule

// File: tb/tb_axi_uart_tx_slave.sv
// tb_axi_uart_tx_slave: random AXI-Lite traffic checked against expected byte lists and a line-level 8N1 frame decoder
module tb_axi_uart_tx_slave;
  localparam int C = 4;
  localparam int D = 16;
  localparam int FRAME = 10 * C;
  logic clk = 1'b0;
  logic aresetn = 1'b1;
  logic [3:0] awaddr = '0, araddr = '0, wstrb = '0;
  logic [31:0] wdata = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;
  logic awready, wready, arready, bvalid, rvalid, tx;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;
  axi_uart_tx_slave #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .tx(tx)
  );
  task automatic do_reset();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    @(posedge clk); #2 aresetn = 1'b0;
    repeat (3) @(posedge clk);
    #2 aresetn = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    awaddr = a; wdata = d; wstrb = 4'($urandom); awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(awready && wready) && n < 50);
    vectors++;
    if (!(awready && wready)) begin
      errors++;
      $display("FAIL write_accept addr %h: awready %b wready %b, want 1 1", a, awready, wready);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 50);
    vectors++;
    if (!bvalid) begin
      errors++;
      $display("FAIL write_bvalid addr %h: bvalid %b, want 1", a, bvalid);
      return;
    end
    resp = bresp;
    @(posedge clk); #1;
  endtask
  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    d = 'x;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    vectors++;
    if (!arready) begin
      errors++;
      $display("FAIL read_accept addr %h: arready %b, want 1", a, arready);
      arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1 arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 50);
    vectors++;
    if (!rvalid || rresp !== 2'b00) begin
      errors++;
      $display("FAIL read_rvalid addr %h: rvalid %b rresp %b, want 1 00", a, rvalid, rresp);
      return;
    end
    d = rdata;
    @(posedge clk); #1;
  endtask
  // waits up to limit cycles for a start bit, then decodes one 8N1 frame and checks each bit lasts C cycles
  task automatic rx_frame(input int limit, output logic [7:0] b, output int idle, output bit ok);
    logic s [FRAME];
    idle = 0; ok = 1'b0; b = 'x;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (tx === 1'b0) begin ok = 1'b1; break; end
      idle++;
    end
    if (!ok) return;
    s[0] = 1'b0;
    for (int k = 1; k < FRAME; k++) begin @(negedge clk); s[k] = tx; end
    for (int i = 0; i < 8; i++) b[i] = s[(i + 1) * C];
    for (int k = 0; k < FRAME; k++)
      if (s[k] !== (k < C ? 1'b0 : k >= 9 * C ? 1'b1 : b[k / C - 1])) ok = 1'b0;
  endtask
  task automatic test_reset();
    awaddr = 4'h4; araddr = 4'h8; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #2 aresetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, tx} !== 10'b00000_00_00_1) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: aw/w/ar/b/r ready-valid,bresp,rresp,tx = %b, want 0000000001", i,
                 {awready, wready, arready, bvalid, rvalid, bresp, rresp, tx});
      end
      vectors++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #2 aresetn = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_single_frame();
    logic [1:0] r; logic [7:0] b; int idle; bit ok;
    do_reset();
    fork
      axi_write(4'h4, 32'hABCD_EF41, r);
      rx_frame(20, b, idle, ok);
    join
    vectors++;
    if (r !== 2'b00) begin errors++; $display("FAIL single_bresp: got %b want 00", r); end
    vectors++;
    if (!ok || b !== 8'h41) begin errors++; $display("FAIL single_frame: ok %0d byte %h, want 1 41", ok, b); end
  endtask
  task automatic test_stat_and_noop();
    logic [31:0] d; logic [1:0] r; logic [7:0] b; int idle; bit ok;
    do_reset();
    axi_read(4'h8, d);
    vectors++;
    if (d !== 32'h4) begin errors++; $display("FAIL stat_after_reset: got %h want 4", d); end
    axi_read(4'h0, d);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL rx_fifo_read: got %h want 0", d); end
    axi_write(4'h0, $urandom, r);
    vectors++;
    if (r !== 2'b00) begin errors++; $display("FAIL noop_rx_bresp: got %b want 00", r); end
    axi_write(4'h8, $urandom, r);
    vectors++;
    if (r !== 2'b00) begin errors++; $display("FAIL noop_stat_bresp: got %b want 00", r); end
    axi_write(4'hC, {$urandom} & 32'hFFFF_FFFE, r);
    vectors++;
    if (r !== 2'b00) begin errors++; $display("FAIL noop_ctrl_bresp: got %b want 00", r); end
    rx_frame(3 * FRAME, b, idle, ok);
    vectors++;
    if (ok) begin errors++; $display("FAIL noop_no_frame: frame seen with byte %h, want none", b); end
  endtask
  task automatic test_fill();
    logic [7:0] q [D + 2];
    do_reset();
    foreach (q[i]) q[i] = 8'($urandom);
    fork
      begin
        logic [1:0] r; logic [31:0] d;
        for (int i = 0; i < D + 2; i++) begin
          if (i == D + 1) begin
            axi_read(4'h8, d);
            vectors++;
            if (d !== 32'h8) begin errors++; $display("FAIL stat_full: got %h want 8", d); end
          end
          axi_write(4'h4, {24'($urandom), q[i]}, r);
          vectors++;
          if (r !== (i < D + 1 ? 2'b00 : 2'b10))
            begin errors++; $display("FAIL fill_bresp[%0d]: got %b want %b", i, r, i < D + 1 ? 2'b00 : 2'b10); end
        end
      end
      begin
        logic [7:0] b; int idle; bit ok;
        for (int i = 0; i < D + 1; i++) begin
          rx_frame(2 * FRAME, b, idle, ok);
          vectors++;
          if (!ok || b !== q[i] || (i > 0 && idle != 1)) begin
            errors++;
            $display("FAIL fill_frame[%0d]: ok %0d byte %h gap %0d, want 1 %h 1", i, ok, b, idle, q[i]);
          end
        end
      end
    join
    begin
      logic [31:0] d; logic [7:0] b; int idle; bit ok;
      axi_read(4'h8, d);
      vectors++;
      if (d !== 32'h4) begin errors++; $display("FAIL stat_drained: got %h want 4", d); end
      rx_frame(3 * FRAME, b, idle, ok);
      vectors++;
      if (ok) begin errors++; $display("FAIL fill_discarded: extra frame byte %h, want none", b); end
    end
  endtask
  task automatic test_bready_hold();
    logic [1:0] r0;
    do_reset();
    bready = 1'b0;
    awaddr = 4'h4; wdata = $urandom; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    vectors++;
    if (!(awready && wready)) begin errors++; $display("FAIL hold_first_accept: awready %b wready %b want 1 1", awready, wready); end
    @(posedge clk); #1 wdata = $urandom;
    @(negedge clk);
    r0 = bresp;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({bvalid, bresp, awready, wready} !== 5'b1_00_00 || bresp !== r0) begin
        errors++;
        $display("FAIL hold_cycle[%0d]: bvalid,bresp,awready,wready = %b, want 10000", i, {bvalid, bresp, awready, wready});
      end
      @(negedge clk);
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bvalid, awready} !== 2'b01) begin errors++; $display("FAIL hold_release: bvalid,awready = %b, want 01", {bvalid, awready}); end
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bvalid, bresp} !== 3'b1_00) begin errors++; $display("FAIL hold_second_resp: bvalid,bresp = %b, want 100", {bvalid, bresp}); end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid_frame();
    logic [1:0] r0, r1; logic [7:0] b0, b; logic [31:0] d; int idle, n; bit ok;
    do_reset();
    b0 = 8'($urandom);
    fork
      begin axi_write(4'h4, {24'h0, b0}, r0); axi_write(4'h4, 32'h0, r1); end
      rx_frame(20, b, idle, ok);
    join
    vectors++;
    if (!ok || b !== b0 || r0 !== 2'b00 || r1 !== 2'b00)
      begin errors++; $display("FAIL rst_first_frame: ok %0d byte %h resp %b %b, want 1 %h 00 00", ok, b, r0, r1, b0); end
    n = 0;
    do begin @(negedge clk); n++; end while (tx !== 1'b0 && n < 10);
    repeat (2 * C) @(negedge clk);
    vectors++;
    if (tx !== 1'b0) begin errors++; $display("FAIL rst_second_data_bit: tx %b want 0", tx); end
    #2 aresetn = 1'b0;
    #1;
    vectors++;
    if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx_immediate: tx %b want 1", tx); end
    repeat (2) @(posedge clk);
    #2 aresetn = 1'b1;
    @(posedge clk); #1;
    axi_read(4'h8, d);
    vectors++;
    if (d !== 32'h4) begin errors++; $display("FAIL rst_stat: got %h want 4", d); end
    rx_frame(3 * FRAME, b, idle, ok);
    vectors++;
    if (ok) begin errors++; $display("FAIL rst_tx_idle: frame byte %h after reset, want none", b); end
  endtask
  task automatic test_ctrl_clear();
    logic [7:0] q [4];
    logic [31:0] d;
    do_reset();
    foreach (q[i]) q[i] = 8'($urandom);
    fork
      begin
        logic [1:0] r;
        for (int i = 0; i < 4; i++) begin
          axi_write(4'h4, {24'($urandom), q[i]}, r);
          vectors++;
          if (r !== 2'b00) begin errors++; $display("FAIL clear_push_bresp[%0d]: got %b want 00", i, r); end
        end
        axi_write(4'hC, 32'h1, r);
        vectors++;
        if (r !== 2'b00) begin errors++; $display("FAIL clear_bresp: got %b want 00", r); end
      end
      begin
        logic [7:0] b; int idle; bit ok;
        rx_frame(20, b, idle, ok);
        vectors++;
        if (!ok || b !== q[0]) begin errors++; $display("FAIL clear_current_frame: ok %0d byte %h, want 1 %h", ok, b, q[0]); end
        rx_frame(3 * FRAME, b, idle, ok);
        vectors++;
        if (ok) begin errors++; $display("FAIL clear_no_more_frames: frame byte %h, want none", b); end
      end
    join
    axi_read(4'h8, d);
    vectors++;
    if (d !== 32'h4) begin errors++; $display("FAIL clear_stat: got %h want 4", d); end
  endtask
  task automatic test_back_to_back_random();
    for (int it = 0; it < 3; it++) begin
      logic [7:0] q [8];
      int n;
      logic [31:0] d;
      do_reset();
      n = $urandom_range(2, 8);
      foreach (q[i]) q[i] = 8'($urandom);
      fork
        begin
          logic [1:0] r; logic [3:0] a;
          for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
              a = 4'($urandom_range(0, 2) * 4);
              a = a == 4'h4 ? 4'hC : a;
              axi_write(a, {$urandom} & 32'hFFFF_FFFE, r);
              vectors++;
              if (r !== 2'b00) begin errors++; $display("FAIL rand_noop_bresp[%0d] addr %h: got %b want 00", i, a, r); end
            end
            axi_write(4'h4, {24'($urandom), q[i]}, r);
            vectors++;
            if (r !== 2'b00) begin errors++; $display("FAIL rand_push_bresp[%0d]: got %b want 00", i, r); end
          end
        end
        begin
          logic [7:0] b; int idle; bit ok;
          for (int i = 0; i < n; i++) begin
            rx_frame(2 * FRAME, b, idle, ok);
            vectors++;
            if (!ok || b !== q[i] || (i > 0 && idle != 1)) begin
              errors++;
              $display("FAIL rand_frame[%0d.%0d]: ok %0d byte %h gap %0d, want 1 %h 1", it, i, ok, b, idle, q[i]);
            end
          end
        end
      join
      axi_read(4'h8, d);
      vectors++;
      if (d !== 32'h4) begin errors++; $display("FAIL rand_stat_drained[%0d]: got %h want 4", it, d); end
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors %0d miscompares so far", vectors, errors);
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_single_frame();
    test_stat_and_noop();
    test_fill();
    test_bready_hold();
    test_reset_mid_frame();
    test_ctrl_clear();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
